// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch (IF) and load/store (LS), one transaction in flight.
// Latency : grant is combinational from mem_gnt; response reaches the owner one cycle after mem_rvalid.
// Backpressure: a request refused by memory is locked and re-presented unchanged until granted.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_req/if_addr/if_gnt       fetch request channel; if_rvalid/if_rdata fetch response
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata/ls_gnt   load/store request channel
//   ls_rvalid/ls_rdata          load data / store acknowledge
//   mem_req/we/be/addr/wdata, mem_gnt            memory request channel
//   mem_rvalid/mem_rdata        memory response
//
// Optional build macro ARB_BACK_TO_BACK_EN: arbitrate in the response cycle of BUSY,
// removing the idle bubble between transactions.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [3:0]      ls_be,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int            CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic          owner_ls_q;    // 0 = IF owns the transaction, 1 = LS
  logic          lock_q;        // a refused request is waiting to be re-presented
  logic          lock_ls_q;     // which requester the lock belongs to
  logic [CW-1:0] starve_cnt_q;

  logic arb_en;
  logic sel_vld;
  logic sel_ls;
  logic grant;

  // Arbitration is allowed in IDLE; with back-to-back enabled, also in the
  // BUSY cycle that carries the response.
`ifdef ARB_BACK_TO_BACK_EN
  assign arb_en = (state_q == IDLE) || mem_rvalid;
`else
  assign arb_en = (state_q == IDLE);
`endif

  // Requester selection: lock first, then forced IF on starvation, then LS priority.
  always_comb begin
    sel_vld = 1'b0;
    sel_ls  = 1'b0;
    if (lock_q) begin
      sel_vld = 1'b1;
      sel_ls  = lock_ls_q;
    end else if ((starve_cnt_q == STARVE_LIM) && if_req) begin
      sel_vld = 1'b1;
      sel_ls  = 1'b0;
    end else if (ls_req) begin
      sel_vld = 1'b1;
      sel_ls  = 1'b1;
    end else if (if_req) begin
      sel_vld = 1'b1;
      sel_ls  = 1'b0;
    end
  end

  // Gate with rst so nothing leaks out combinationally while reset is held.
  assign mem_req   = arb_en && sel_vld && !rst;
  assign grant     = mem_req && mem_gnt;
  assign if_gnt    = grant && !sel_ls;
  assign ls_gnt    = grant && sel_ls;

  assign mem_we    = sel_ls ? ls_we    : 1'b0;
  assign mem_be    = sel_ls ? ls_be    : 4'hF;
  assign mem_addr  = sel_ls ? ls_addr  : if_addr;
  assign mem_wdata = sel_ls ? ls_wdata : '0;

  // Next state: a response ends the transaction; a grant (possibly in the
  // same cycle when back-to-back is enabled) starts the next one.
  always_comb begin
    state_d = state_q;
    if ((state_q == BUSY) && mem_rvalid) begin
      state_d = IDLE;
    end
    if (grant) begin
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership, lock and starvation tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_ls_q   <= 1'b0;
      lock_q       <= 1'b0;
      lock_ls_q    <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      if (grant) begin
        owner_ls_q <= sel_ls;
        lock_q     <= 1'b0;
      end else if (mem_req) begin
        lock_q     <= 1'b1;
        lock_ls_q  <= sel_ls;
      end

      // A fetch that is no longer waiting cannot be starved.
      if (!if_req) begin
        starve_cnt_q <= '0;
      end else if (grant) begin
        if (sel_ls) begin
          starve_cnt_q <= (starve_cnt_q == STARVE_LIM) ? STARVE_LIM : starve_cnt_q + 1'b1;
        end else begin
          starve_cnt_q <= '0;
        end
      end
    end
  end

  // Registered response routing; uses the owner of the finishing transaction
  // even if a new grant overwrites owner_ls_q in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if ((state_q == BUSY) && mem_rvalid) begin
        if (owner_ls_q) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_rdata;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory port between the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the fetch/LSU stages and the memory interface.
- Allows one outstanding transaction at a time. LS has fixed priority; a starvation counter bounds how long a waiting fetch can be blocked.
- Responses are registered and routed back to the requester that owns the transaction.

Parameters:
- XLEN, 32 (from instructions_pkg): address/data width.
- STARVE_MAX, 4: consecutive LS grants allowed while if_req is pending, before IF is forced through.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  XLEN  fetch address
- if_gnt  out  1  fetch request accepted
- if_rvalid  out  1  fetch data valid (1-cycle pulse)
- if_rdata  out  XLEN  fetch data
- ls_req  in  1  load/store request
- ls_we  in  1  1 = store
- ls_be  in  4  byte enables
- ls_addr  in  XLEN  load/store address
- ls_wdata  in  XLEN  store data
- ls_gnt  out  1  LS request accepted
- ls_rvalid  out  1  load data / store ack valid (1-cycle pulse)
- ls_rdata  out  XLEN  load data
- mem_req  out  1  request to memory
- mem_we  out  1  write enable
- mem_be  out  4  byte enables
- mem_addr  out  XLEN  address
- mem_wdata  out  XLEN  write data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response valid
- mem_rdata  in  XLEN  memory response data

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, owner=IF, lock=0, starve_cnt=0; all *_rvalid=0, all *_rdata=0. mem_req, if_gnt and ls_gnt are 0 during reset.
- FSM has two states, IDLE and BUSY.
- Selection in IDLE:
  - If lock=1, use the locked requester.
  - Else if starve_cnt==STARVE_MAX and if_req=1, select IF.
  - Else if ls_req=1, select LS.
  - Else if if_req=1, select IF.
- IDLE outputs: mem_req=1 when a requester is selected. mem_addr/we/be/wdata are driven combinationally from the selected requester. IF requests drive mem_we=0, mem_be=4'hF, mem_wdata=0.
- No grant (mem_req=1, mem_gnt=0): lock=1 and the selection is held. The selection must not change until granted, even if the higher-priority LS asserts meanwhile.
- Grant (mem_req=1, mem_gnt=1):
  - The selected *_gnt is asserted in the same cycle (combinational from mem_gnt).
  - owner is latched, lock is cleared, FSM moves to BUSY.
- BUSY: mem_req=0 and both gnt outputs are 0. On mem_rvalid, the owner's rvalid pulses 1 cycle later with rdata = registered mem_rdata, and FSM returns to IDLE. The next request is issued in the cycle after mem_rvalid.
- The non-owner rdata register holds its previous value.
- mem_rvalid while IDLE is ignored: no rvalid pulse, no state change.
- starve_cnt, updated on each grant:
  - LS granted while if_req=1: starve_cnt = min(starve_cnt+1, STARVE_MAX).
  - IF granted, or if_req=0 in any cycle: starve_cnt=0.
- Stores are acknowledged via ls_rvalid. ls_rdata is updated with mem_rdata regardless of ls_we.
- Reset asserted mid-transaction: the outstanding transaction is dropped. A late mem_rvalid after reset falls in IDLE and is ignored.
- Requesters hold req and payload stable until gnt (requester rule). The arbiter does not re-check this.

Optional Feature:
- Macro: ARB_BACK_TO_BACK_EN.
- Defined: in BUSY, the cycle in which mem_rvalid=1 also performs IDLE-style selection and may assert mem_req, and its gnt if mem_gnt=1. This removes the one-cycle bubble. The response pulse still occurs one cycle later, to the previous owner.
- Not defined: as in Behaviour; mem_req=0 for the whole BUSY state.

Test Plan:
- IF-only read: if_req=1, if_addr=0x100; mem_gnt=1 in the same cycle; mem_rvalid with mem_rdata=0xDEADBEEF 2 cycles later -> if_gnt pulses once, if_rvalid=1 with if_rdata=0xDEADBEEF one cycle after mem_rvalid; ls_rvalid stays 0.
- Simultaneous requests: if_req=ls_req=1, starve_cnt=0 -> LS granted first (mem_addr=ls_addr, mem_we=ls_we, mem_be=ls_be); IF granted on the next arbitration.
- Starvation: ls_req held 1 and if_req held 1 with STARVE_MAX=4 -> 4 LS grants, then the 5th grant goes to IF and starve_cnt returns to 0.
- Lock: IF selected with mem_gnt=0 for 3 cycles, ls_req rises in cycle 2 -> mem_addr stays if_addr until mem_gnt; if_gnt=1 and ls_gnt=0.
- Reset mid-transaction: assert rst while BUSY, release, then pulse mem_rvalid -> no *_rvalid pulse, FSM=IDLE, all outputs at reset values.
- Back-to-back, with ARB_BACK_TO_BACK_EN: mem_req=1 in the mem_rvalid cycle. Without the macro: mem_req=0 in that cycle.
